// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and helpers for tick_generator
package tick_gen_pkg;
  localparam int CNT_W_DEF = 27;
  localparam int DEFAULT_DIV_DEF = 100000000;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] high_len(input logic [31:0] d);
    return d - (d >> 1);
  endfunction
endpackage

// File: rtl/tick_gen_channel.sv
// tick_gen_channel: one divider channel with shadow/active divisor and registered tick/clk_out
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             align,
  input  logic             wr,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             clk_out
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] cnt, active, shadow, cnt_n, active_n, shadow_n;
  logic load;
  // Outputs are registered from the next counter state so they line up with cnt.
  always_comb begin
    shadow_n = wr ? div : shadow;
    load = !en || align || cnt == active - 1'b1;
    cnt_n = load ? '0 : cnt + 1'b1;
    active_n = load ? shadow_n : active;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      active <= DEF;
      shadow <= DEF;
      tick <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt <= cnt_n;
      active <= active_n;
      shadow <= shadow_n;
      tick <= en && !align && cnt_n == active_n - 1'b1;
      clk_out <= en && 32'(cnt_n) < high_len(32'(active_n));
    end
  end
endmodule

// File: rtl/tick_generator.sv
// tick_generator: multi-channel programmable tick/square-wave generator.
// Optional TICK_GEN_ALIGN_EN adds an align input that restarts all enabled channels.
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef TICK_GEN_ALIGN_EN
  input  logic              align,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);
  logic align_i, bad;
`ifdef TICK_GEN_ALIGN_EN
  assign align_i = align;
`else
  assign align_i = 1'b0;
`endif
  assign bad = cfg_div == '0 || int'(cfg_ch) >= NUM_CH;
  always_ff @(posedge clk) cfg_err <= reset ? 1'b0 : cfg_we && bad;
  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    tick_gen_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk(clk),
      .rst(reset),
      .en(ch_en[i]),
      .align(align_i),
      .wr(cfg_we && !bad && cfg_ch == CH_W'(i)),
      .div(cfg_div),
      .tick(tick[i]),
      .clk_out(clk_out[i])
    );
  end
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed self-checking bench for tick_generator (4- and 3-channel instances)
module tb_tick_generator;
  logic clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, bad_we = 1'b0;
  logic [3:0] ch_en = 4'h0, tick, clk_out;
  logic [2:0] tick3, clk_out3;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic cfg_err, cfg_err3;
`ifdef TICK_GEN_ALIGN_EN
  logic align = 1'b0;
`endif
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  tick_generator #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(10)) dut (
    .clk(clk),
    .reset(reset),
`ifdef TICK_GEN_ALIGN_EN
    .align(align),
`endif
    .ch_en(ch_en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .tick(tick),
    .clk_out(clk_out)
  );

  tick_generator #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(10)) dut3 (
    .clk(clk),
    .reset(reset),
`ifdef TICK_GEN_ALIGN_EN
    .align(align),
`endif
    .ch_en(ch_en[2:0]),
    .cfg_we(cfg_we | bad_we),
    .cfg_ch(bad_we ? 2'd3 : cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err3),
    .tick(tick3),
    .clk_out(clk_out3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] dv);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_div = dv;
  endtask

  initial begin
    int c[4], d[4];
    logic [3:0] et, eh;
    step();
    step();
    chk("reset_tick", tick, 4'h0);
    chk("reset_clk_out", clk_out, 4'h0);
    chk("reset_cfg_err", {3'b0, cfg_err}, 4'h0);
    chk("reset_tick3", {1'b0, tick3}, 4'h0);
    reset = 1'b0;
    ch_en = 4'hF;
    // k counts edges since release; channel count k sits in the cycle after edge k
    for (int k = 1; k <= 36; k++) begin
      step();
      c[0] = k % 10; d[0] = 10;
      c[1] = k < 10 ? k : (k - 10) % 5; d[1] = k < 10 ? 10 : 5;
      c[2] = k < 10 ? k : k <= 30 ? (k - 10) % 3 : 0; d[2] = k < 10 ? 10 : k <= 30 ? 3 : 1;
      c[3] = k < 8 ? k : (k - 11) % 10; d[3] = 10;
      for (int i = 0; i < 4; i++) begin
        et[i] = c[i] == d[i] - 1;
        eh[i] = c[i] < d[i] - d[i] / 2;
      end
      if (k >= 8 && k <= 11) begin
        et[3] = 1'b0;
        eh[3] = 1'b0;
      end
      chk("tick", tick, et);
      chk("clk_out", clk_out, eh);
      chk("tick3", {1'b0, tick3}, {1'b0, et[2:0]});
      chk("clk_out3", {1'b0, clk_out3}, {1'b0, eh[2:0]});
      chk("cfg_err", {3'b0, cfg_err}, {3'b0, k == 15});
      chk("cfg_err3", {3'b0, cfg_err3}, {3'b0, k == 15 || k == 21});
      case (k)
        2: wr(2'd1, 8'd5);
        9: wr(2'd2, 8'd3);
        14: wr(2'd0, 8'd0);
        30: wr(2'd2, 8'd1);
        3, 10, 15, 31: cfg_we = 1'b0;
        20: begin bad_we = 1'b1; cfg_div = 8'd7; end
        21: bad_we = 1'b0;
        7: ch_en[3] = 1'b0;
        11: ch_en[3] = 1'b1;
        default: ;
      endcase
    end
    // reset mid-period together with a write: write discarded, all channels back to 10
    reset = 1'b1;
    wr(2'd0, 8'd3);
    step();
    chk("midreset_tick", tick, 4'h0);
    chk("midreset_clk_out", clk_out, 4'h0);
    reset = 1'b0;
    cfg_we = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("post_reset_tick", tick, j % 10 == 9 ? 4'hF : 4'h0);
      chk("post_reset_clk_out", clk_out, j % 10 < 5 ? 4'hF : 4'h0);
      chk("post_reset_tick3", {1'b0, tick3}, j % 10 == 9 ? 4'h7 : 4'h0);
    end
`ifdef TICK_GEN_ALIGN_EN
    wr(2'd0, 8'd4);
    step();
    wr(2'd1, 8'd6);
    step();
    cfg_we = 1'b0;
    align = 1'b1;
    step();
    align = 1'b0;
    chk("align_tick", {2'b0, tick[1:0]}, 4'h0);
    chk("align_clk_out", {2'b0, clk_out[1:0]}, 4'h3);
    for (int j = 1; j <= 24; j++) begin
      step();
      chk("align_run_tick", {2'b0, tick[1:0]}, {2'b0, j % 6 == 5, j % 4 == 3});
      chk("align_run_clk_out", {2'b0, clk_out[1:0]}, {2'b0, j % 6 < 3, j % 4 < 2});
    end
    reset = 1'b1;
    align = 1'b1;
    step();
    chk("reset_align_tick", tick, 4'h0);
    reset = 1'b0;
    align = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("reset_align_run", tick, j == 9 ? 4'hF : 4'h0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
